// File: rtl/stopwatch_pkg.sv
// Shared types, digit limits and run/lap state encodings for the SS.hh stopwatch.
package stopwatch_pkg;

  typedef logic [3:0] bcd_t;

  localparam int NUM_DIGITS = 4;

  // Index 0 is hundredths, index 3 is tens of seconds.
  localparam bcd_t DIGIT_LIMIT [NUM_DIGITS] = '{4'd9, 4'd9, 4'd9, 4'd5};

  // Encoding is {running, lap_hold} so the outputs are the state bits directly.
  typedef enum logic [1:0] {
    STOP     = 2'b00,
    STOP_LAP = 2'b01,
    RUN      = 2'b10,
    RUN_LAP  = 2'b11
  } sw_state_t;

  // Value of a decade after one edge; anything at or above the limit folds to 0.
  function automatic bcd_t bcd_step(bcd_t q, bcd_t limit, logic inc);
    if (!inc) return q;
    return (q >= limit) ? 4'd0 : q + 4'd1;
  endfunction

endpackage

// File: rtl/bcd_digit_counter.sv
// One decade of the stopwatch: counts 0..LIMIT and carries out on rollover.
module bcd_digit_counter
  import stopwatch_pkg::*;
#(
  parameter bcd_t LIMIT = 4'd9
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic inc,
  output bcd_t q,
  output logic carry_out
);

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      q <= '0;
    end else begin
      q <= bcd_step(q, LIMIT, inc);
    end
  end

  assign carry_out = inc & (q == LIMIT);

endmodule

// File: rtl/stopwatch_bcd_counter.sv
// 00.00..59.99 stopwatch: prescaler, run/lap FSM, four chained decades and a lap latch.
module stopwatch_bcd_counter
  import stopwatch_pkg::*;
#(
  parameter int CLK_HZ  = 50_000_000,
  parameter int TICK_HZ = 100
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_stop,
  input  logic       clear,
  input  logic       lap,
  output logic [3:0] bcd0,
  output logic [3:0] bcd1,
  output logic [3:0] bcd2,
  output logic [3:0] bcd3,
  output logic       running,
  output logic       lap_hold,
  output logic       tick,
  output logic       wrap
);

  localparam int DIV   = CLK_HZ / TICK_HZ;
  localparam int PRE_W = $clog2(DIV);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV - 1);

  sw_state_t                   state;
  logic [PRE_W-1:0]            pre;
  logic [NUM_DIGITS:0]         carry;
  bcd_t [NUM_DIGITS-1:0]       live;
  bcd_t [NUM_DIGITS-1:0]       live_next;
  bcd_t [NUM_DIGITS-1:0]       latch;
  bcd_t [NUM_DIGITS-1:0]       shown;

  assign running = state[1];
  assign lap_hold = state[0];

  // start_stop still toggles under clear; clear only forces the lap bit low.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= STOP;
    end else begin
      state <= sw_state_t'({state[1] ^ start_stop, ~clear & (state[0] ^ lap)});
    end
  end

  // Held while stopped so a resumed run continues mid-period.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      pre <= '0;
    end else if (running) begin
      pre <= (pre == PRE_LAST) ? '0 : pre + PRE_W'(1);
    end
  end

  assign tick     = running & (pre == PRE_LAST);
  assign carry[0] = tick;
  assign wrap     = carry[NUM_DIGITS];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      bcd_digit_counter #(
        .LIMIT(DIGIT_LIMIT[gi])
      ) u_digit (
        .clk      (clk),
        .reset    (reset),
        .clr      (clear),
        .inc      (carry[gi]),
        .q        (live[gi]),
        .carry_out(carry[gi+1])
      );

      assign live_next[gi] = bcd_step(live[gi], DIGIT_LIMIT[gi], carry[gi]);
      assign shown[gi]     = lap_hold ? latch[gi] : live[gi];
    end
  endgenerate

  // Capture the post-edge value so a tick on the freezing edge is included.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      latch <= '0;
    end else if (lap && !lap_hold) begin
      latch <= live_next;
    end
  end

  assign bcd0 = shown[0];
  assign bcd1 = shown[1];
  assign bcd2 = shown[2];
  assign bcd3 = shown[3];

endmodule

// File: tb/tb_stopwatch_bcd_counter.sv
// Scoreboard bench for stopwatch_bcd_counter with DIV=10 (CLK_HZ=1000, TICK_HZ=100).
module tb_stopwatch_bcd_counter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start_stop = 1'b0;
  logic       clear = 1'b0;
  logic       lap = 1'b0;
  logic [3:0] bcd0, bcd1, bcd2, bcd3;
  logic       running, lap_hold, tick, wrap;

  always #5 clk = ~clk;

  stopwatch_bcd_counter #(
    .CLK_HZ (1000),
    .TICK_HZ(100)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start_stop(start_stop),
    .clear     (clear),
    .lap       (lap),
    .bcd0      (bcd0),
    .bcd1      (bcd1),
    .bcd2      (bcd2),
    .bcd3      (bcd3),
    .running   (running),
    .lap_hold  (lap_hold),
    .tick      (tick),
    .wrap      (wrap)
  );

  typedef struct packed {
    logic [15:0] bcd;
    logic        running;
    logic        lap_hold;
    logic        tick;
    logic        wrap;
  } obs_t;

  obs_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Behavioural model: count held as an integer number of hundredths.
  int   m_cnt = 0, m_latch = 0, m_pre = 0;
  bit   m_run = 0, m_hold = 0;
  int   tick_seen = 0, wrap_seen = 0, run_clks = 0;

  task automatic check_val(string tag, logic [31:0] got, logic [31:0] expv);
    vectors++;
    if (got !== expv) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, expv);
    end else begin
      $display("%s ok: %0h", tag, got);
    end
  endtask

  function automatic logic [15:0] to_bcd(int v);
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic logic [15:0] shown_bcd();
    return {bcd3, bcd2, bcd1, bcd0};
  endfunction

  task automatic step(bit ss, bit clr, bit lp, bit rst, bit chk, string tag);
    obs_t e;
    obs_t got;
    bit   t;
    @(negedge clk);
    start_stop = ss;
    clear      = clr;
    lap        = lp;
    reset      = rst;
    t = m_run && (m_pre == 9);
    if (m_run && !rst) run_clks++;
    if (rst) begin
      m_cnt = 0; m_latch = 0; m_pre = 0; m_run = 0; m_hold = 0;
    end else begin
      if (m_run) m_pre = (m_pre == 9) ? 0 : m_pre + 1;
      if (t) m_cnt = (m_cnt + 1) % 6000;
      if (clr) begin
        m_cnt = 0; m_pre = 0; m_latch = 0; m_hold = 0;
      end else begin
        if (lp && !m_hold) m_latch = m_cnt;
        if (lp) m_hold = !m_hold;
      end
      if (ss) m_run = !m_run;
    end
    e.bcd      = to_bcd(m_hold ? m_latch : m_cnt);
    e.running  = m_run;
    e.lap_hold = m_hold;
    e.tick     = m_run && (m_pre == 9);
    e.wrap     = e.tick && (m_cnt == 5999);
    if (chk) exp_q.push_back(e);
    @(posedge clk);
    #1;
    got = {bcd3, bcd2, bcd1, bcd0, running, lap_hold, tick, wrap};
    if (tick) tick_seen++;
    if (wrap) wrap_seen++;
    if (chk) begin
      e = exp_q.pop_front();
      check_val(tag, 32'(got), 32'(e));
    end
  endtask

  // Idle-run (no inputs) until the model reaches the requested count/prescaler.
  task automatic run_to(int c, int p, bit chk, string tag);
    int n = 0;
    while (!(m_cnt == c && m_pre == p) && n < 70000) begin
      step(0, 0, 0, 0, chk, tag);
      n++;
    end
    check_val({tag, "_reached"}, 32'(n < 70000), 32'd1);
  endtask

  initial begin
    // Reset state
    step(0, 0, 0, 1, 1, "reset");
    step(0, 0, 0, 1, 1, "reset");
    step(0, 0, 0, 0, 1, "idle");

    // 1: start, 100 clocks -> 10 ticks, 00.10
    step(1, 0, 0, 0, 1, "start");
    tick_seen = 0;
    repeat (100) step(0, 0, 0, 0, 1, "run100");
    check_val("s1_ticks", 32'(tick_seen), 32'd10);
    check_val("s1_bcd", 32'(shown_bcd()), 32'h0010);
    check_val("s1_running", 32'(running), 32'd1);

    // 2: multi-level carry 09.99 -> 10.00, then 59.99 -> 00.00 with one-cycle wrap
    run_to(999, 0, 0, "to_0999");
    repeat (10) step(0, 0, 0, 0, 1, "carry");
    check_val("s2_carry_bcd", 32'(shown_bcd()), 32'h1000);
    run_to(5999, 0, 0, "to_5999");
    wrap_seen = 0;
    repeat (10) step(0, 0, 0, 0, 1, "wrap");
    check_val("s2_wrap_count", 32'(wrap_seen), 32'd1);
    check_val("s2_wrap_bcd", 32'(shown_bcd()), 32'h0000);
    check_val("s2_wrap_running", 32'(running), 32'd1);

    // 3: stop at 00.05 with pre=4, idle, resume; tick after 6 running clocks
    run_to(5, 4, 0, "to_0005");
    run_clks = 0;
    step(1, 0, 0, 0, 1, "stop");
    repeat (50) step(0, 0, 0, 0, 0, "idle50");
    check_val("s3_held_bcd", 32'(shown_bcd()), 32'h0005);
    check_val("s3_held_running", 32'(running), 32'd0);
    step(1, 0, 0, 0, 1, "resume");
    begin
      int n = 0;
      while (bcd0 == 4'd5 && n < 20) begin
        step(0, 0, 0, 0, 1, "resume_run");
        n++;
      end
    end
    check_val("s3_run_clks", 32'(run_clks), 32'd6);

    // 4: lap freeze at 01.23 while live reaches 01.40, then release
    run_to(123, 0, 0, "to_0123");
    step(0, 0, 1, 0, 1, "lap_on");
    check_val("s4_frozen_bcd", 32'(shown_bcd()), 32'h0123);
    run_to(140, 0, 1, "frozen_run");
    check_val("s4_still_frozen", 32'(shown_bcd()), 32'h0123);
    step(0, 0, 1, 0, 1, "lap_off");
    check_val("s4_live_bcd", 32'(shown_bcd()), 32'h0140);
    check_val("s4_lap_hold", 32'(lap_hold), 32'd0);

    // 5: clear coincident with tick while RUN and lap held; then clear + start_stop
    step(0, 0, 1, 0, 1, "lap_on2");
    run_to(140, 9, 1, "to_tick");
    check_val("s5_tick_pending", 32'(tick), 32'd1);
    step(0, 1, 0, 0, 1, "clear_tick");
    check_val("s5_bcd", 32'(shown_bcd()), 32'h0000);
    check_val("s5_running", 32'(running), 32'd1);
    check_val("s5_lap_hold", 32'(lap_hold), 32'd0);
    tick_seen = 0;
    repeat (10) step(0, 0, 0, 0, 1, "after_clear");
    check_val("s5_pre_zeroed", 32'(tick_seen), 32'd1);
    check_val("s5_bcd_one", 32'(shown_bcd()), 32'h0001);
    step(1, 1, 0, 0, 1, "clear_stop");
    check_val("s5_cs_bcd", 32'(shown_bcd()), 32'h0000);
    check_val("s5_cs_running", 32'(running), 32'd0);

    // 6: reset mid-run at 12.34 with lap held
    step(1, 0, 0, 0, 1, "start2");
    run_to(1234, 0, 0, "to_1234");
    step(0, 0, 1, 0, 1, "lap_1234");
    check_val("s6_lap_bcd", 32'(shown_bcd()), 32'h1234);
    step(0, 0, 0, 1, 1, "mid_reset");
    check_val("s6_all_zero", 32'({shown_bcd(), running, lap_hold, tick, wrap}), 32'd0);
    tick_seen = 0;
    repeat (30) step(0, 0, 0, 0, 1, "post_reset");
    check_val("s6_no_ticks", 32'(tick_seen), 32'd0);
    step(1, 0, 0, 0, 1, "restart");
    repeat (10) step(0, 0, 0, 0, 1, "restart_run");
    check_val("s6_restart_ticks", 32'(tick_seen), 32'd1);

    check_val("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
